// File: rtl/hex_display_ctrl.sv
// N-digit seven-segment controller: buffered hex/raw message shown static, scrolling or blinking,
// with a caller pattern override. All outputs are registered.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_DEPTH  = 16,
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned SCROLL_HZ  = 4,
    parameter int unsigned BLINK_HZ   = 2,
    parameter bit          ACTIVE_LOW = 1'b1,
    localparam int unsigned AW        = $clog2(MSG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [7:0]              wr_data,
    input  logic [AW:0]             msg_len,
    input  logic [1:0]              mode,
    input  logic                    override,
    input  logic [7*NUM_DIGITS-1:0] override_pattern,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    wrap_pulse
);

    localparam int unsigned SEG_W      = 7 * NUM_DIGITS;
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned SCROLL_DIV = CLK_HZ / SCROLL_HZ;
    localparam int unsigned BLINK_DIV  = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SCW        = $clog2(SCROLL_DIV + 1);
    localparam int unsigned BCW        = $clog2(BLINK_DIV + 1);
    localparam int unsigned IW         = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;

    logic [7:0]       msg_q [MSG_DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d, ptr_eff;
    logic [SCW-1:0]   scroll_cnt_q, scroll_cnt_d;
    logic [BCW-1:0]   blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [1:0]       mode_q;
    logic             wrap_q, wrap_d;
    logic [SEG_W-1:0] seg_q, seg_d, raw_d;
    logic [LW-1:0]    len;
    logic             mode_chg, scroll_tick, blink_tick, blink_off, ptr_stale;

    function automatic logic [6:0] decode(input logic [7:0] c);
        logic [6:0] s;
        if (c[7]) begin
            s = c[6:0];
        end else begin
            case (c[3:0])
                4'h0: s = 7'h3F;
                4'h1: s = 7'h06;
                4'h2: s = 7'h5B;
                4'h3: s = 7'h4F;
                4'h4: s = 7'h66;
                4'h5: s = 7'h6D;
                4'h6: s = 7'h7D;
                4'h7: s = 7'h07;
                4'h8: s = 7'h7F;
                4'h9: s = 7'h6F;
                4'hA: s = 7'h77;
                4'hB: s = 7'h7C;
                4'hC: s = 7'h39;
                4'hD: s = 7'h5E;
                4'hE: s = 7'h79;
                4'hF: s = 7'h71;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        len         = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
        mode_chg    = (mode != mode_q);
        scroll_tick = (scroll_cnt_q == SCW'(SCROLL_DIV - 1));
        blink_tick  = (blink_cnt_q == BCW'(BLINK_DIV - 1));
        ptr_stale   = ({1'b0, ptr_q} >= len);
        // A mode change restarts scroll/blink on the same edge the content switches.
        ptr_eff     = (mode_chg || ptr_stale) ? '0 : ptr_q;
        blink_off   = mode[1] && !mode_chg && !blink_on_q;
    end

    always_comb begin
        scroll_cnt_d = scroll_tick ? '0 : scroll_cnt_q + SCW'(1);
        blink_cnt_d  = blink_tick ? '0 : blink_cnt_q + BCW'(1);
        blink_on_d   = blink_tick ? !blink_on_q : blink_on_q;
        ptr_d        = ptr_q;
        wrap_d       = 1'b0;
        if (mode_chg) begin
            scroll_cnt_d = '0;
            blink_cnt_d  = '0;
            blink_on_d   = 1'b1;
            ptr_d        = '0;
        end else if (len == '0 || ptr_stale) begin
            ptr_d = '0;
        end else if (scroll_tick && mode[0]) begin
            if ({1'b0, ptr_q} == len - LW'(1)) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_comb begin
        logic [IW-1:0] idx;
        raw_d = '0;
        idx   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (len == '0) begin
                raw_d[7*k +: 7] = 7'h00;
            end else if (mode[0]) begin
                // Leftmost digit (k = NUM_DIGITS-1) shows the entry at ptr.
                idx = IW'(ptr_eff) + IW'(NUM_DIGITS - 1 - k);
                for (int n = 0; n < NUM_DIGITS; n++) begin
                    if (idx >= IW'(len)) idx = idx - IW'(len);
                end
                raw_d[7*k +: 7] = decode(msg_q[idx[AW-1:0]]);
            end else if (LW'(k) < len) begin
                raw_d[7*k +: 7] = decode(msg_q[AW'(k)]);
            end
            if (blink_off) raw_d[7*k +: 7] = 7'h00;
        end
        seg_d = override ? override_pattern : raw_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) msg_q[i] <= 8'h80;
            ptr_q        <= '0;
            scroll_cnt_q <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            mode_q       <= 2'b00;
            wrap_q       <= 1'b0;
            seg_q        <= {SEG_W{ACTIVE_LOW}};
        end else begin
            if (wr_en) msg_q[wr_addr] <= wr_data;
            ptr_q        <= ptr_d;
            scroll_cnt_q <= scroll_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            mode_q       <= mode;
            wrap_q       <= wrap_d;
            seg_q        <= ACTIVE_LOW ? ~seg_d : seg_d;
        end
    end

    assign seg_out    = seg_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl at CLK_HZ=40 (scroll tick and blink half-period = 10 cycles).
module tb_hex_display_ctrl;

    localparam logic [41:0] ALL1 = {42{1'b1}};
    localparam logic [41:0] PAT  = 42'h2AA_AAAA_AAAA;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  msg_len;
    logic [1:0]  mode;
    logic        override;
    logic [41:0] override_pattern;
    logic [41:0] seg_out;
    logic        wrap_pulse;

    int vectors = 0;
    int miscompares = 0;
    logic wrap_seen;
    logic blank_bad;
    logic [41:0] exp_v;

    hex_display_ctrl #(
        .NUM_DIGITS(6),
        .MSG_DEPTH (16),
        .CLK_HZ    (40),
        .SCROLL_HZ (4),
        .BLINK_HZ  (2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .msg_len         (msg_len),
        .mode            (mode),
        .override        (override),
        .override_pattern(override_pattern),
        .seg_out         (seg_out),
        .wrap_pulse      (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; 4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Arguments are digit 5 (leftmost) down to digit 0; result is active-low.
    function automatic logic [41:0] show(input logic [3:0] h5, input logic [3:0] h4,
                                         input logic [3:0] h3, input logic [3:0] h2,
                                         input logic [3:0] h1, input logic [3:0] h0);
        return ~{hexseg(h5), hexseg(h4), hexseg(h3), hexseg(h2), hexseg(h1), hexseg(h0)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; mode = 2'b00; override = 1'b0; override_pattern = '0;

        // Reset
        step(3);
        check("reset_seg", seg_out, ALL1);
        check("reset_wrap", 42'(wrap_pulse), 42'd0);
        reset = 1'b0;
        step(1);
        check("post_reset_seg", seg_out, ALL1);

        // Static
        msg_len = 5'd6;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i);
            step(1);
        end
        wr_en = 1'b0;
        check("static_d5_not_yet", 42'(seg_out[41:35]), 42'h7F);
        check("static_d0", 42'(seg_out[6:0]), 42'h40);
        step(1);
        check("static_d5", 42'(seg_out[41:35]), 42'h12);
        check("static_all", seg_out, show(5, 4, 3, 2, 1, 0));

        // Scroll over 8 entries
        for (int i = 6; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i);
            step(1);
        end
        wr_en = 1'b0; msg_len = 5'd8; mode = 2'b01;
        step(1);
        check("scroll_p0", seg_out, show(0, 1, 2, 3, 4, 5));
        step(10);
        check("scroll_p0_hold", seg_out, show(0, 1, 2, 3, 4, 5));
        step(1);
        check("scroll_p1", seg_out, show(1, 2, 3, 4, 5, 6));
        step(68);
        check("wrap_before", 42'(wrap_pulse), 42'd0);
        step(1);
        check("wrap_pulse", 42'(wrap_pulse), 42'd1);
        check("scroll_p7", seg_out, show(7, 0, 1, 2, 3, 4));
        step(1);
        check("wrap_after", 42'(wrap_pulse), 42'd0);
        check("scroll_back_p0", seg_out, show(0, 1, 2, 3, 4, 5));

        // Override during scroll; pointer keeps running underneath
        override = 1'b1; override_pattern = 42'h0;
        step(1);
        check("ovr_on", seg_out, ALL1);
        step(24);
        check("ovr_hold", seg_out, ALL1);
        override = 1'b0;
        step(1);
        check("ovr_release_p2", seg_out, show(2, 3, 4, 5, 6, 7));

        // Blink on static content
        mode = 2'b10;
        step(1);
        check("blink_on_start", seg_out, show(5, 4, 3, 2, 1, 0));
        step(10);
        check("blink_on_end", seg_out, show(5, 4, 3, 2, 1, 0));
        step(1);
        check("blink_off_start", seg_out, ALL1);
        step(4);
        override = 1'b1; override_pattern = PAT;
        step(1);
        check("ovr_in_blink_off", seg_out, ~PAT);
        override = 1'b0;
        step(1);
        check("blink_off_after_ovr", seg_out, ALL1);
        step(3);
        check("blink_off_end", seg_out, ALL1);
        step(1);
        check("blink_on_again", seg_out, show(5, 4, 3, 2, 1, 0));
        step(14);
        check("blink_off_mid", seg_out, ALL1);
        mode = 2'b00;
        step(1);
        check("static_restored", seg_out, show(5, 4, 3, 2, 1, 0));

        // Zero length, then length clamped to 16
        mode = 2'b01; msg_len = 5'd0;
        step(1);
        check("len0_blank_start", seg_out, ALL1);
        wrap_seen = 1'b0; blank_bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (wrap_pulse) wrap_seen = 1'b1;
            if (seg_out !== ALL1) blank_bad = 1'b1;
        end
        check("len0_no_wrap", 42'(wrap_seen), 42'd0);
        check("len0_all_blank", 42'(blank_bad), 42'd0);
        msg_len = 5'd20;
        step(11);
        check("len16_p1", seg_out, show(1, 2, 3, 4, 5, 6));
        step(148);
        check("len16_wrap_before", 42'(wrap_pulse), 42'd0);
        step(1);
        check("len16_wrap", 42'(wrap_pulse), 42'd1);
        exp_v = show(0, 0, 1, 2, 3, 4);
        exp_v[41:35] = 7'h7F;
        check("len16_p15_disp", seg_out, exp_v);

        // Mid-scroll reset clears buffer and pointer
        reset = 1'b1;
        step(1);
        check("mid_reset_seg", seg_out, ALL1);
        check("mid_reset_wrap", 42'(wrap_pulse), 42'd0);
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h86;
        step(1);
        check("after_reset_blank", seg_out, ALL1);
        wr_en = 1'b0;
        step(1);
        check("raw_at_ptr0", seg_out, {7'h79, {35{1'b1}}});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
